crc_frame_tx: RTL and testbench

CRC_FRAME_TX -- requirements
Module: crc_frame_tx

---
 rtl/crc_frame_pkg.sv | 19 +
 rtl/crc_frame_if.sv | 31 +++
 rtl/crc_frame_ser.sv | 57 +++++
 rtl/crc_frame_tx.sv | 121 ++++++++++++
 tb/tb_crc_frame_tx.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_frame_pkg.sv
// Shared definitions for the CRC frame transmitter: FSM encoding, frame size, timeout default.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package crc_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CRC_WAIT = 2'd1,
    ST_SEND     = 2'd2
  } state_t;

  // 8 payload bytes followed by one CRC byte
  localparam int FRAME_BYTES = 9;
  localparam int IDX_W       = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/crc_frame_if.sv
// Bundle of payload input, crc_8 side-channel and byte output of the frame transmitter.
// Latency: n/a (wiring only).
// Backpressure: din_vld/din_rdy on input, tx_vld/tx_rdy on output.
interface crc_frame_if;

  logic [63:0] din;
  logic        din_vld;
  logic        din_rdy;
  logic [63:0] crc_din;
  logic        crc_start;
  logic        crc_vld;
  logic [7:0]  crc_o;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        busy;
  logic        err;

  // slave: the transmitter itself
  modport slave (
    input  din, din_vld, crc_vld, crc_o, tx_rdy,
    output din_rdy, crc_din, crc_start, tx_data, tx_vld, busy, err
  );

  // master: whatever feeds words, models crc_8 and sinks bytes
  modport master (
    output din, din_vld, crc_vld, crc_o, tx_rdy,
    input  din_rdy, crc_din, crc_start, tx_data, tx_vld, busy, err
  );

endinterface

// File: rtl/crc_frame_ser.sv
// Byte serializer: walks a 64-bit word MSB byte first, then the CRC byte, over a valid/ready port.
// Latency: first byte registered one cycle after load; one byte per cycle when tx_rdy stays high.
// Backpressure: tx_rdy low holds tx_vld and tx_data unchanged; nothing advances until a transfer.
module crc_frame_ser
  import crc_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] word,
  input  logic [7:0]  crc,
  input  logic        tx_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  output logic        done
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  logic [63:0]      word_sh;
  logic [7:0]       byte_nxt;
  logic             xfer;
  logic             last;

  assign xfer = tx_vld && tx_rdy;
  assign last = (idx_q == LAST_IDX);
  assign done = xfer && last;

  // Pick the byte for the next index: slots 0..7 come from the word, slot 8 is the CRC
  always_comb begin
    idx_nxt  = load ? '0 : idx_q + IDX_W'(1);
    word_sh  = word << {idx_nxt[2:0], 3'b000};
    byte_nxt = idx_nxt[IDX_W-1] ? crc : word_sh[63:56];
  end

  // Index, registered valid and registered byte; only a transfer or a load moves them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      tx_vld  <= 1'b0;
      tx_data <= '0;
    end else if (load) begin
      idx_q   <= '0;
      tx_vld  <= 1'b1;
      tx_data <= byte_nxt;
    end else if (xfer) begin
      if (last) begin
        idx_q  <= '0;
        tx_vld <= 1'b0;
      end else begin
        idx_q   <= idx_nxt;
        tx_data <= byte_nxt;
      end
    end
  end

endmodule

// File: rtl/crc_frame_tx.sv
// Frame transmitter: takes a 64-bit word, asks crc_8 for its CRC, then emits 8 payload bytes + CRC.
// Latency: first byte 2 cycles after the accept cycle when crc_vld is already up; 9 bytes back to back.
// Backpressure: din_rdy only in IDLE; tx_rdy low stalls SEND indefinitely. CRC_TIMEOUT_EN adds a CRC wait timeout.
module crc_frame_tx
  import crc_frame_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  crc_frame_if.slave bus
);

  state_t      state_q;
  state_t      state_d;
  logic [63:0] crc_din_q;
  logic [7:0]  crc_q;
  logic        accept;
  logic        crc_hit;
  logic        timeout;
  logic        load_ser;
  logic        ser_done;

  assign accept  = (state_q == ST_IDLE) && bus.din_vld;
  assign crc_hit = (state_q == ST_CRC_WAIT) && bus.crc_vld;
  assign bus.crc_din = crc_din_q;

`ifdef CRC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  // crc_vld in the final wait cycle still wins over the timeout
  assign timeout = (state_q == ST_CRC_WAIT) && !bus.crc_vld && (to_cnt_q == TO_LAST);
  assign bus.err = err_q;

  // Count CRC_WAIT cycles from zero on every entry; err is a one-cycle echo of the timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout;
      if (accept)
        to_cnt_q <= '0;
      else if (state_q == ST_CRC_WAIT)
        to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next state, serializer load strobe and state-decoded outputs
  always_comb begin
    state_d       = state_q;
    load_ser      = 1'b0;
    bus.din_rdy   = 1'b0;
    bus.busy      = 1'b1;
    bus.crc_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.din_rdy = 1'b1;
        bus.busy    = 1'b0;
        if (bus.din_vld)
          state_d = ST_CRC_WAIT;
      end
      ST_CRC_WAIT: begin
        bus.crc_start = 1'b1;
        if (bus.crc_vld) begin
          state_d  = ST_SEND;
          load_ser = 1'b1;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (ser_done)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Payload captured on accept and held for the whole frame; CRC byte captured on crc_vld
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_din_q <= '0;
      crc_q     <= '0;
    end else begin
      if (accept)
        crc_din_q <= bus.din;
      if (crc_hit)
        crc_q <= bus.crc_o;
    end
  end

  crc_frame_ser u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_ser),
    .word    (crc_din_q),
    .crc     (crc_q),
    .tx_rdy  (bus.tx_rdy),
    .tx_data (bus.tx_data),
    .tx_vld  (bus.tx_vld),
    .done    (ser_done)
  );

endmodule

// File: tb/tb_crc_frame_tx.sv
// Self-checking bench for crc_frame_tx: reference byte order from plain arithmetic, crc_8 modelled
// as a programmable-latency responder, randomized payloads, CRC bytes, latencies and tx_rdy patterns.
// Covers reset, latency, stalls, back-to-back, mid-frame reset, and the CRC wait with/without timeout.
module tb_crc_frame_tx;

`ifdef CRC_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  crc_frame_if bus();

  crc_frame_tx #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // crc_8 model: answers crc_lat cycles into a crc_start run, if enabled
  bit         crc_en = 1'b0;
  int         crc_lat = 1;
  logic [7:0] crc_val = 8'h00;
  int         start_run = 0;

  always @(negedge clk) begin
    if (!bus.crc_start) begin
      start_run   = 0;
      bus.crc_vld = 1'b0;
    end else begin
      start_run   = start_run + 1;
      bus.crc_vld = crc_en && (start_run >= crc_lat);
    end
    bus.crc_o = crc_val;
  end

  // Reference: frame is the word MSB byte first, then the CRC byte
  function automatic logic [7:0] exp_byte(input logic [63:0] d, input logic [7:0] c, input int i);
    if (i == 8) return c;
    return 8'((d >> (8 * (7 - i))) & 64'hFF);
  endfunction

  // Observations of the last frame
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         first_vld;
  int         start_cnt;
  int         stall_bad;
  int         rdy_in_frame;
  int         crc_din_bad;
  int         err_cnt;

  // Offer one word and collect transferred bytes. Cycle 0 is the accept cycle.
  // mode: 0 tx_rdy high, 1 toggling, 3 low until cycle 30, else random.
  task automatic run_frame(input logic [63:0] d, input logic [7:0] c, input int lat,
                           input int mode, input bit hold, input int max_bytes);
    bit         stalled;
    logic [7:0] prev;
    int         n;
    got_q.delete(); got_cyc.delete();
    first_vld = -1; start_cnt = 0; stall_bad = 0; rdy_in_frame = 0; crc_din_bad = 0; err_cnt = 0;
    crc_val = c; crc_lat = lat; crc_en = 1'b1;
    n = 0;
    while (!bus.din_rdy && n < 200) begin @(negedge clk); n++; end
    bus.din = d; bus.din_vld = 1'b1; bus.tx_rdy = (mode == 0);
    @(negedge clk);
    if (hold) bus.din = {$urandom, $urandom};
    else bus.din_vld = 1'b0;
    stalled = 1'b0; prev = 8'h00;
    for (int cyc = 1; cyc < 3000 && got_q.size() < max_bytes; cyc++) begin
      if (cyc > 1) @(negedge clk);
      case (mode)
        0: bus.tx_rdy = 1'b1;
        1: bus.tx_rdy = (cyc % 2 == 0);
        3: bus.tx_rdy = (cyc >= 30);
        default: bus.tx_rdy = 1'($urandom_range(0, 1));
      endcase
      if (bus.crc_start) start_cnt++;
      if (bus.din_rdy) rdy_in_frame++;
      if (bus.crc_din !== d) crc_din_bad++;
      if (bus.err) err_cnt++;
      if (bus.tx_vld && first_vld < 0) first_vld = cyc;
      if (stalled && bus.tx_data !== prev) stall_bad++;
      if (bus.tx_vld && bus.tx_rdy) begin got_q.push_back(bus.tx_data); got_cyc.push_back(cyc); end
      stalled = bus.tx_vld && !bus.tx_rdy;
      prev = bus.tx_data;
    end
  endtask

  task automatic test_reset();
    bus.din = '0; bus.din_vld = 1'b0; bus.tx_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.din_rdy !== 1'b1) begin errors++; $display("FAIL reset_din_rdy: got %b want 1", bus.din_rdy); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.crc_start !== 1'b0) begin errors++; $display("FAIL reset_crc_start: got %b want 0", bus.crc_start); end
    checks++; if (bus.tx_vld !== 1'b0) begin errors++; $display("FAIL reset_tx_vld: got %b want 0", bus.tx_vld); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.crc_din !== 64'h0) begin errors++; $display("FAIL reset_crc_din: got %h want 0", bus.crc_din); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    logic [63:0] d = 64'hFFFF_FFFF_FFFF_FFFF;
    run_frame(d, 8'h3C, 3, 0, 1'b0, 9);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++; if (g !== exp_byte(d, 8'h3C, i)) begin errors++; $display("FAIL ones_byte%0d: got %h want %h", i, g, exp_byte(d, 8'h3C, i)); end
    end
    checks++; if (start_cnt !== 3) begin errors++; $display("FAIL ones_crc_start_cycles: got %0d want 3", start_cnt); end
    checks++; if (first_vld !== 4) begin errors++; $display("FAIL ones_first_vld: got %0d want 4", first_vld); end
    checks++; if (got_cyc.size() != 9 || got_cyc[8] - got_cyc[0] != 8) begin errors++; $display("FAIL ones_consecutive: got %0d bytes want 9 over 9 cycles", got_cyc.size()); end
    @(negedge clk);
    checks++; if (bus.din_rdy !== 1'b1 || bus.tx_vld !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ones_idle_after: got rdy=%b vld=%b busy=%b want 1 0 0", bus.din_rdy, bus.tx_vld, bus.busy); end
  endtask

  task automatic test_min_latency();
    logic [63:0] d = {$urandom, $urandom};
    logic [7:0]  c = 8'($urandom);
    run_frame(d, c, 1, 0, 1'b0, 9);
    checks++; if (first_vld !== 2) begin errors++; $display("FAIL minlat_first_vld: got %0d want 2", first_vld); end
    checks++; if (start_cnt !== 1) begin errors++; $display("FAIL minlat_crc_start_cycles: got %0d want 1", start_cnt); end
    for (int i = 0; i < 9; i++) begin
      logic [7:0] g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++; if (g !== exp_byte(d, c, i)) begin errors++; $display("FAIL minlat_byte%0d: got %h want %h", i, g, exp_byte(d, c, i)); end
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [63:0] d = 64'hABCD_ABCD_ABCD_ABCD;
    logic [7:0]  c = 8'($urandom);
    run_frame(d, c, 2, 1, 1'b0, 9);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++; if (g !== exp_byte(d, c, i)) begin errors++; $display("FAIL toggle_byte%0d: got %h want %h", i, g, exp_byte(d, c, i)); end
    end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL toggle_stall_stable: got %0d changes want 0", stall_bad); end
    @(negedge clk);
    d = {$urandom, $urandom};
    run_frame(d, c, 1, 3, 1'b0, 9);
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL long_stall_stable: got %0d changes want 0", stall_bad); end
    checks++; if (got_cyc.size() == 0 || got_cyc[0] !== 30) begin errors++; $display("FAIL long_stall_first_xfer: got %0d bytes want first at cycle 30", got_cyc.size()); end
    for (int i = 0; i < 9; i++) begin
      logic [7:0] g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++; if (g !== exp_byte(d, c, i)) begin errors++; $display("FAIL long_stall_byte%0d: got %h want %h", i, g, exp_byte(d, c, i)); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] d = 64'hAAAA_BBBB_CCCC_DDDD;
    logic [7:0]  c = 8'($urandom);
    run_frame(d, c, 2, 2, 1'b1, 9);
    checks++; if (rdy_in_frame !== 0) begin errors++; $display("FAIL b2b_din_rdy_busy: got %0d cycles want 0", rdy_in_frame); end
    checks++; if (crc_din_bad !== 0) begin errors++; $display("FAIL b2b_crc_din_held: got %0d bad cycles want 0", crc_din_bad); end
    for (int i = 0; i < 9; i++) begin
      logic [7:0] g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++; if (g !== exp_byte(d, c, i)) begin errors++; $display("FAIL b2b_first_byte%0d: got %h want %h", i, g, exp_byte(d, c, i)); end
    end
    @(negedge clk);
    checks++; if (bus.din_rdy !== 1'b1 || bus.crc_start !== 1'b0) begin errors++; $display("FAIL b2b_gap: got rdy=%b start=%b want 1 0", bus.din_rdy, bus.crc_start); end
    run_frame(d, ~c, 1, 0, 1'b0, 9);
    checks++; if (first_vld !== 2) begin errors++; $display("FAIL b2b_second_accept: got first_vld %0d want 2", first_vld); end
    for (int i = 0; i < 9; i++) begin
      logic [7:0] g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++; if (g !== exp_byte(d, ~c, i)) begin errors++; $display("FAIL b2b_second_byte%0d: got %h want %h", i, g, exp_byte(d, ~c, i)); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [63:0] d = {$urandom, $urandom};
    logic [7:0]  c = 8'($urandom);
    run_frame(d, c, 1, 0, 1'b0, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.tx_vld !== 1'b0) begin errors++; $display("FAIL midrst_tx_vld: got %b want 0", bus.tx_vld); end
    checks++; if (bus.busy !== 1'b0 || bus.din_rdy !== 1'b1) begin errors++; $display("FAIL midrst_idle: got busy=%b rdy=%b want 0 1", bus.busy, bus.din_rdy); end
    checks++; if (bus.tx_data !== 8'h00 || bus.crc_din !== 64'h0) begin errors++; $display("FAIL midrst_clear: got tx_data=%h crc_din=%h want 0", bus.tx_data, bus.crc_din); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.tx_vld !== 1'b0) begin errors++; $display("FAIL midrst_no_resume: got tx_vld %b want 0", bus.tx_vld); end
    d = {$urandom, $urandom};
    run_frame(d, c, 1, 2, 1'b0, 9);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++; if (g !== exp_byte(d, c, i)) begin errors++; $display("FAIL midrst_next_byte%0d: got %h want %h", i, g, exp_byte(d, c, i)); end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      logic [63:0] d = {$urandom, $urandom};
      logic [7:0]  c = 8'($urandom);
      int          lat = $urandom_range(1, 4);
      run_frame(d, c, lat, 2, 1'b0, 9);
      checks++; if (first_vld !== lat + 1) begin errors++; $display("FAIL rand%0d_first_vld: got %0d want %0d", f, first_vld, lat + 1); end
      checks++; if (start_cnt !== lat) begin errors++; $display("FAIL rand%0d_crc_start: got %0d want %0d", f, start_cnt, lat); end
      checks++; if (stall_bad !== 0 || err_cnt !== 0) begin errors++; $display("FAIL rand%0d_stall_err: got %0d/%0d want 0/0", f, stall_bad, err_cnt); end
      for (int i = 0; i < 9; i++) begin
        logic [7:0] g = (i < got_q.size()) ? got_q[i] : 8'hxx;
        checks++; if (g !== exp_byte(d, c, i)) begin errors++; $display("FAIL rand%0d_byte%0d: got %h want %h", f, i, g, exp_byte(d, c, i)); end
      end
      @(negedge clk);
    end
  endtask

`ifdef CRC_TIMEOUT_EN
  task automatic test_timeout();
    int n_start = 0, n_err = 0, err_at = -1, n_tx = 0;
    logic rdy_at_err = 1'b0;
    logic [63:0] d = {$urandom, $urandom};
    logic [7:0]  c = 8'($urandom);
    crc_en = 1'b0;
    bus.din = {$urandom, $urandom}; bus.din_vld = 1'b1; bus.tx_rdy = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (bus.crc_start) n_start++;
      if (bus.tx_vld) n_tx++;
      if (bus.err) begin n_err++; if (err_at < 0) begin err_at = cyc; rdy_at_err = bus.din_rdy; end end
    end
    checks++; if (n_err !== 1) begin errors++; $display("FAIL timeout_err_count: got %0d want 1", n_err); end
    checks++; if (err_at !== 17) begin errors++; $display("FAIL timeout_err_cycle: got %0d want 17", err_at); end
    checks++; if (n_start !== 16) begin errors++; $display("FAIL timeout_wait_cycles: got %0d want 16", n_start); end
    checks++; if (n_tx !== 0) begin errors++; $display("FAIL timeout_no_tx: got %0d want 0", n_tx); end
    checks++; if (rdy_at_err !== 1'b1) begin errors++; $display("FAIL timeout_din_rdy: got %b want 1", rdy_at_err); end
    run_frame(d, c, 16, 0, 1'b0, 9);
    checks++; if (err_cnt !== 0 || start_cnt !== 16) begin errors++; $display("FAIL tie_err_wait: got err=%0d wait=%0d want 0 16", err_cnt, start_cnt); end
    for (int i = 0; i < 9; i++) begin
      logic [7:0] g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++; if (g !== exp_byte(d, c, i)) begin errors++; $display("FAIL tie_byte%0d: got %h want %h", i, g, exp_byte(d, c, i)); end
    end
    @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    int n_start = 0, n_err = 0, n_tx = 0;
    logic [7:0] first_b = 8'hxx;
    logic [63:0] d = {$urandom, $urandom};
    crc_en = 1'b0; crc_lat = 1; crc_val = 8'($urandom);
    bus.din = d; bus.din_vld = 1'b1; bus.tx_rdy = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (bus.crc_start) n_start++;
      if (bus.err) n_err++;
      if (bus.tx_vld) n_tx++;
    end
    checks++; if (n_start !== 300 || bus.busy !== 1'b1) begin errors++; $display("FAIL nto_wait: got %0d start cycles busy=%b want 300 1", n_start, bus.busy); end
    checks++; if (n_err !== 0 || n_tx !== 0) begin errors++; $display("FAIL nto_quiet: got err=%0d tx=%0d want 0 0", n_err, n_tx); end
    crc_en = 1'b1;
    n_tx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (bus.tx_vld && bus.tx_rdy) begin if (n_tx == 0) first_b = bus.tx_data; n_tx++; end
    end
    checks++; if (n_tx !== 9) begin errors++; $display("FAIL nto_late_frame: got %0d bytes want 9", n_tx); end
    checks++; if (first_b !== exp_byte(d, crc_val, 0)) begin errors++; $display("FAIL nto_first_byte: got %h want %h", first_b, exp_byte(d, crc_val, 0)); end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ones();
    test_min_latency();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef CRC_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
